// File: rtl/icache_1way.sv
// icache_1way: direct-mapped, read-only instruction cache.
// Hits are served from flop-based line storage one cycle after the request is
// sampled. Misses refill the whole line, word 0 first, over a valid/ready port.
// Optional feature: define ICACHE_STATS_EN to add the hit_count/miss_count outputs.

module icache_1way #(
   parameter int unsigned NUM_SETS   = 64,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        proc_valid,
   output logic        proc_ready,
   input  logic [31:0] proc_addr,
   output logic [31:0] proc_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
`ifdef ICACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   input  logic [31:0] mem_req_rdata
);

   localparam int unsigned WordBits = $clog2(LINE_WORDS);
   localparam int unsigned SetBits  = $clog2(NUM_SETS);
   // Keep index vectors at least one bit wide for degenerate sizes.
   localparam int unsigned CntW     = (WordBits > 0) ? WordBits : 1;
   localparam int unsigned SetW     = (SetBits > 0) ? SetBits : 1;
   localparam int unsigned TagW     = 30 - SetBits - WordBits;
   localparam logic [31:0] WordMask = 32'(LINE_WORDS - 1);
   localparam logic [31:0] SetMask  = 32'(NUM_SETS - 1);
   localparam logic [31:0] LineMask = 32'(LINE_WORDS * 4 - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(LINE_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StRefill, StResp} state_e;

   state_e              state_q, state_d;
   logic [31:0]         addr_q, addr_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                skip_q, skip_d;
   logic [NUM_SETS-1:0] valid_q, valid_d;

   logic [TagW-1:0]     tag_q [NUM_SETS];
   logic [31:0]         data_q [NUM_SETS][LINE_WORDS];

   logic [CntW-1:0]     lk_word, rf_word;
   logic [SetW-1:0]     lk_set, rf_set;
   logic [TagW-1:0]     lk_tag, rf_tag;
   logic                lk_hit;
   logic                fill_we, fill_last;
   logic [31:0]         refill_addr;
   logic                unused_addr_lsb;

   // Byte-offset bits are meaningless for word fetches.
   assign unused_addr_lsb = ^proc_addr[1:0];

   // Lookup fields come straight from the request; refill fields from the latched address.
   assign lk_word = CntW'((proc_addr >> 2) & WordMask);
   assign lk_set  = SetW'((proc_addr >> (WordBits + 2)) & SetMask);
   assign lk_tag  = TagW'(proc_addr >> (SetBits + WordBits + 2));
   assign rf_word = CntW'((addr_q >> 2) & WordMask);
   assign rf_set  = SetW'((addr_q >> (WordBits + 2)) & SetMask);
   assign rf_tag  = TagW'(addr_q >> (SetBits + WordBits + 2));
   assign lk_hit  = valid_q[lk_set] && (tag_q[lk_set] == lk_tag);

   assign refill_addr = (addr_q & ~LineMask) | (32'(cnt_q) << 2);
   assign proc_rdata  = rdata_q;

   // Next-state, refill sequencing and handshake outputs.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      valid_d       = valid_q;
      skip_d        = 1'b0;
      proc_ready    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = 32'd0;
      fill_we       = 1'b0;
      fill_last     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // skip_q blocks re-acknowledging a request still held after RESP.
            if (proc_valid && !skip_q) begin
               addr_d = proc_addr;
               if (lk_hit) begin
                  rdata_d = data_q[lk_set][lk_word];
                  state_d = StResp;
               end else begin
                  cnt_d   = '0;
                  state_d = StRefill;
               end
            end
         end
         StRefill: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = refill_addr;
            if (mem_req_ready) begin
               fill_we = 1'b1;
               if (cnt_q == rf_word) begin
                  rdata_d = mem_req_rdata;
               end
               if (cnt_q == LastCnt) begin
                  fill_last       = 1'b1;
                  valid_d[rf_set] = 1'b1;
                  cnt_d           = '0;
                  state_d         = StResp;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StResp: begin
            // A request dropped mid-refill gets no acknowledge.
            proc_ready = proc_valid;
            skip_d     = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
         addr_q  <= 32'd0;
         cnt_q   <= '0;
         rdata_q <= 32'd0;
         skip_q  <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         skip_q  <= skip_d;
         valid_q <= valid_d;
      end
   end

   // Line storage; contents are qualified by valid_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[rf_set][cnt_q] <= mem_req_rdata;
      end
      if (fill_last) begin
         tag_q[rf_set] <= rf_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic        lookup_go;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   assign lookup_go  = (state_q == StIdle) && proc_valid && !skip_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

   // One increment per IDLE lookup; counters wrap naturally.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else if (lookup_go) begin
         if (lk_hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_1way.sv
// tb_icache_1way: directed bench for icache_1way with an abstract cache model
// (valid/tag per set, expected refill address queue) and a per-cycle compare process.

module tb_icache_1way;

   logic        clk = 1'b0;
   logic        resetn;
   logic        proc_valid;
   logic        proc_ready;
   logic [31:0] proc_addr;
   logic [31:0] proc_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_rdata;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache_1way #(
      .NUM_SETS  (64),
      .LINE_WORDS(4)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .proc_valid   (proc_valid),
      .proc_ready   (proc_ready),
      .proc_addr    (proc_addr),
      .proc_rdata   (proc_rdata),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr (mem_req_addr),
`ifdef ICACHE_STATS_EN
      .hit_count    (hit_count),
      .miss_count   (miss_count),
`endif
      .mem_req_rdata(mem_req_rdata)
   );

   always #5 clk = ~clk;

   // Instruction memory image: upper half is the inverted lower half of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign mem_req_rdata = mem_word(mem_req_addr);

   int          checks   = 0;
   int          failures = 0;
   int          stall_cfg = 0;
   int          wait_cnt  = 0;
   int          hs        = 0;
   int          acks      = 0;
   int          m_hits    = 0;
   int          m_misses  = 0;
   logic [31:0] exp_data  = 32'd0;
   logic [31:0] last_rdata = 32'd0;
   logic [31:0] exp_addrs[$];
   logic [31:0] hs_log[$];
   bit          mv[64];
   logic [21:0] mt[64];

   bit          prev_valid = 1'b0;
   bit          prev_ready = 1'b0;
   bit          prev_pready = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: stall_cfg idle cycles before accepting each word.
   always @(negedge clk) begin
      if (resetn && mem_req_valid) begin
         if (wait_cnt >= stall_cfg) begin
            mem_req_ready = 1'b1;
            wait_cnt = 0;
         end else begin
            mem_req_ready = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_req_ready = 1'b0;
         wait_cnt = 0;
      end
   end

   // Compare process: handshakes, request stability and acknowledges every cycle.
   always @(negedge clk) begin
      #1;
      if (!resetn) begin
         prev_valid  = 1'b0;
         prev_ready  = 1'b0;
         prev_pready = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            chk("req_held", {31'd0, mem_req_valid}, 32'd1);
            chk("req_addr_stable", mem_req_addr, prev_addr);
         end
         if (mem_req_valid && mem_req_ready) begin
            hs++;
            hs_log.push_back(mem_req_addr);
            if (exp_addrs.size() == 0) chk("unexpected_refill", mem_req_addr, 32'hFFFF_FFFF);
            else chk("refill_addr", mem_req_addr, exp_addrs.pop_front());
         end
         if (proc_ready) begin
            chk("ack_with_valid", {31'd0, proc_valid}, 32'd1);
            chk("ack_data", proc_rdata, exp_data);
            chk("ack_single_pulse", {31'd0, prev_pready}, 32'd0);
            acks++;
            last_rdata = proc_rdata;
         end
         prev_valid  = mem_req_valid;
         prev_ready  = mem_req_ready;
         prev_addr   = mem_req_addr;
         prev_pready = proc_ready;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mv[i] = 1'b0;
      exp_addrs.delete();
      m_hits   = 0;
      m_misses = 0;
   endtask

   // One fetch: predict hit/miss from the model, then check latency and acknowledge count.
   task automatic fetch(input logic [31:0] a, input int stall, input bit hold_extra);
      int  cyc;
      int  acks0;
      int  exp_lat;
      bit  hit;
      bit  got;
      hit      = mv[a[9:4]] && (mt[a[9:4]] == a[31:10]);
      exp_data = mem_word({a[31:2], 2'b00});
      if (!hit) begin
         for (int w = 0; w < 4; w++) exp_addrs.push_back({a[31:4], 4'(w * 4)});
         m_misses++;
      end else begin
         m_hits++;
      end
      exp_lat   = hit ? 1 : 1 + 4 * (stall + 1);
      stall_cfg = stall;
      acks0     = acks;
      cyc       = 0;
      got       = 1'b0;
      @(posedge clk);
      #2;
      proc_addr  = a;
      proc_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (proc_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat));
      @(posedge clk);
      if (hold_extra) @(posedge clk);
      #2;
      proc_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("ack_count", 32'(acks - acks0), 32'd1);
      chk("refill_drained", 32'(exp_addrs.size()), 32'd0);
      exp_addrs.delete();
      mv[a[9:4]] = 1'b1;
      mt[a[9:4]] = a[31:10];
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, 32'(m_hits));
      chk("miss_count", miss_count, 32'(m_misses));
`endif
   endtask

   task automatic check_reset_outputs();
      chk("rst_proc_ready", {31'd0, proc_ready}, 32'd0);
      chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_proc_rdata", proc_rdata, 32'd0);
      chk("rst_mem_req_addr", mem_req_addr, 32'd0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      resetn     = 1'b0;
      proc_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      model_reset();
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      int  h0;
      bit  reached;
      resetn        = 1'b0;
      proc_valid    = 1'b0;
      proc_addr     = 32'd0;
      mem_req_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      #1;
      resetn = 1'b1;

      // Cold fetch: four word requests from 0x100 upward.
      hs_log.delete();
      fetch(32'h0000_0104, 0, 1'b0);
      chk("cold_data_literal", last_rdata, 32'hFEFB_0104);
      chk("cold_hs_count", 32'(hs_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < hs_log.size(); i++)
         chk("cold_hs_addr_literal", hs_log[i], 32'h100 + 32'(i * 4));

      // Refetch in the filled line: hit, proc_valid held one extra cycle.
      h0 = hs;
      fetch(32'h0000_0108, 0, 1'b1);
      chk("hit_data_literal", last_rdata, 32'hFEF7_0108);
      chk("hit_no_mem_traffic", 32'(hs - h0), 32'd0);
      fetch(32'h0000_010C, 0, 1'b0);

      // Slow memory: five stall cycles per word, conflicting with the line at set 0x10.
      fetch(32'h0000_0504, 5, 1'b0);
      chk("stall_data_literal", last_rdata, 32'hFAFB_0504);
      fetch(32'h0000_0100, 0, 1'b0);

      // Reset in the middle of a refill.
      exp_data = mem_word(32'h240);
      for (int w = 0; w < 4; w++) exp_addrs.push_back(32'h240 + 32'(w * 4));
      stall_cfg = 0;
      h0 = hs;
      @(posedge clk);
      #2;
      proc_addr  = 32'h0000_0240;
      proc_valid = 1'b1;
      reached = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (hs - h0 >= 2) begin
            reached = 1'b1;
            break;
         end
      end
      chk("partial_refill_reached", {31'd0, reached}, 32'd1);
      #1;
      resetn     = 1'b0;
      proc_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_refill_mem_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_mid_refill_proc_ready", {31'd0, proc_ready}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check_reset_outputs();
      #1;
      resetn = 1'b1;
      h0 = hs;
      fetch(32'h0000_0240, 0, 1'b0);
      chk("refill_after_reset", 32'(hs - h0), 32'd4);
      // Previously filled line must be gone after reset.
      h0 = hs;
      fetch(32'h0000_0104, 0, 1'b0);
      chk("valid_cleared_by_reset", 32'(hs - h0), 32'd4);

      // Conflict misses: 0x100 / 0x500 / 0x100 share a set.
      do_reset();
      h0 = hs;
      fetch(32'h0000_0100, 0, 1'b0);
      chk("conflict_a_literal", last_rdata, 32'hFEFF_0100);
      fetch(32'h0000_0500, 0, 1'b0);
      chk("conflict_b_literal", last_rdata, 32'hFAFF_0500);
      fetch(32'h0000_0100, 0, 1'b0);
      chk("conflict_c_literal", last_rdata, 32'hFEFF_0100);
      chk("conflict_refills", 32'(hs - h0), 32'd12);

      // Miss, hit, hit on one line.
      do_reset();
      fetch(32'h0000_0240, 0, 1'b0);
      fetch(32'h0000_0244, 0, 1'b0);
      fetch(32'h0000_0248, 0, 1'b0);
`ifdef ICACHE_STATS_EN
      chk("stats_hits_literal", hit_count, 32'd2);
      chk("stats_misses_literal", miss_count, 32'd1);
`endif
      chk("last_hit_literal", last_rdata, 32'hFDB7_0248);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
